// File: rtl/usb_bulk_in_ctrl.sv
// Bulk-IN transaction controller: answers IN tokens with DATA0/1, NAK or STALL,
// routes the selected endpoint stream to the encoder and tracks data toggles.
module usb_bulk_in_ctrl #(
   parameter int NUM_EPS = 2,
   parameter int TIMEOUT = 200
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [6:0]           usb_addr_i,
   input  logic                 tok_recv_i,
   input  logic [1:0]           tok_type_i,
   input  logic [6:0]           tok_addr_i,
   input  logic [3:0]           tok_endp_i,
   input  logic                 hsk_recv_i,
   input  logic [1:0]           hsk_type_i,
   output logic                 hsk_send_o,
   input  logic                 hsk_sent_i,
   output logic [1:0]           hsk_type_o,
   output logic                 usb_send_o,
   input  logic                 usb_sent_i,
   output logic [1:0]           usb_type_o,
   output logic                 usb_tvalid_o,
   input  logic                 usb_tready_i,
   output logic                 usb_tlast_o,
   output logic [7:0]           usb_tdata_o,
   input  logic [NUM_EPS-1:0]   ep_ready_i,
   input  logic [NUM_EPS-1:0]   ep_halt_i,
   input  logic [NUM_EPS-1:0]   ep_clr_i,
   input  logic [NUM_EPS-1:0]   ep_tvalid_i,
   input  logic [NUM_EPS-1:0]   ep_tlast_i,
   output logic [NUM_EPS-1:0]   ep_tready_o,
   input  logic [8*NUM_EPS-1:0] ep_tdata_i,
   output logic [NUM_EPS-1:0]   ep_done_o,
   output logic [NUM_EPS-1:0]   ep_retry_o,
   output logic [3:0]           ep_sel_o
);

   localparam int         CW      = (NUM_EPS > 1) ? $clog2(NUM_EPS) : 1;
   localparam int         TW      = $clog2(TIMEOUT + 1);
   localparam logic [3:0] MAX_EP  = 4'(NUM_EPS);
   localparam logic [1:0] TOK_IN  = 2'b10;
   localparam logic [1:0] HSK_ACK = 2'b00;
   localparam logic [1:0] HSK_NAK = 2'b10;
   localparam logic [1:0] HSK_STL = 2'b11;

   typedef enum logic [1:0] {S_IDLE, S_HSK, S_DATA, S_WAIT} state_t;

   state_t         state;
   logic [CW-1:0]  ch;
   logic [TW-1:0]  timer;
   logic [NUM_EPS-1:0] toggle;

   logic           tok_ok;
   logic [CW-1:0]  tok_ch;

   assign tok_ok = tok_recv_i && (tok_type_i == TOK_IN) && (tok_addr_i == usb_addr_i)
                   && (tok_endp_i != 4'd0) && (tok_endp_i <= MAX_EP);
   assign tok_ch = CW'(tok_endp_i - 4'd1);

   // Zero-latency stream mux; only the channel in service sees ready.
   always_comb begin
      usb_tvalid_o = 1'b0;
      usb_tlast_o  = 1'b0;
      usb_tdata_o  = 8'd0;
      ep_tready_o  = '0;
      if (state == S_DATA) begin
         usb_tvalid_o    = ep_tvalid_i[ch];
         usb_tlast_o     = ep_tlast_i[ch];
         usb_tdata_o     = ep_tdata_i[8*ch +: 8];
         ep_tready_o[ch] = usb_tready_i;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         // NOTE: the toggle bits are plain flops and must be reset; a host expects DATA0 after bus reset.
         state      <= S_IDLE;
         ch         <= '0;
         timer      <= '0;
         toggle     <= '0;
         hsk_send_o <= 1'b0;
         hsk_type_o <= 2'b00;
         usb_send_o <= 1'b0;
         usb_type_o <= 2'b00;
         ep_done_o  <= '0;
         ep_retry_o <= '0;
         ep_sel_o   <= 4'd0;
      end else begin
         usb_send_o <= 1'b0;
         ep_done_o  <= '0;
         ep_retry_o <= '0;
         case (state)
            S_IDLE: if (tok_ok) begin
               ch       <= tok_ch;
               ep_sel_o <= tok_endp_i;
               if (ep_halt_i[tok_ch]) begin
                  state      <= S_HSK;
                  hsk_send_o <= 1'b1;
                  hsk_type_o <= HSK_STL;
               end else if (!ep_ready_i[tok_ch]) begin
                  state      <= S_HSK;
                  hsk_send_o <= 1'b1;
                  hsk_type_o <= HSK_NAK;
               end else begin
                  state      <= S_DATA;
                  usb_send_o <= 1'b1;
                  usb_type_o <= {toggle[tok_ch], 1'b0};
               end
            end
            S_HSK: if (hsk_sent_i) begin
               hsk_send_o <= 1'b0;
               ep_sel_o   <= 4'd0;
               state      <= S_IDLE;
            end
            S_DATA: if (usb_sent_i) begin
               timer <= TW'(TIMEOUT);
               state <= S_WAIT;
            end
            S_WAIT: begin
               // The decrement that reaches zero is the timeout, so retry lands TIMEOUT+1 cycles after usb_sent.
               timer <= timer - 1'b1;
               if (hsk_recv_i && (hsk_type_i == HSK_ACK)) begin
                  toggle[ch]    <= ~toggle[ch];
                  ep_done_o[ch] <= 1'b1;
                  ep_sel_o      <= 4'd0;
                  state         <= S_IDLE;
               end else if (hsk_recv_i || tok_recv_i || (timer == '0) || (timer == TW'(1))) begin
                  ep_retry_o[ch] <= 1'b1;
                  ep_sel_o       <= 4'd0;
                  state          <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
         // NOTE: placed after the ACK update so the later non-blocking write makes the clear win.
         for (int k = 0; k < NUM_EPS; k++) begin
            if (ep_clr_i[k]) toggle[k] <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_usb_bulk_in_ctrl.sv
// Directed bench for usb_bulk_in_ctrl: data/ACK, NAK, STALL, timeout, invalid
// tokens, toggle clear, aborted WAIT and reset mid-packet.
module tb_usb_bulk_in_ctrl;

   localparam int         NUM_EPS = 2;
   localparam int         TIMEOUT = 20;
   localparam logic [6:0] ADDR    = 7'h2A;

   logic                 clock = 1'b0;
   logic                 reset;
   logic [6:0]           usb_addr_i;
   logic                 tok_recv_i;
   logic [1:0]           tok_type_i;
   logic [6:0]           tok_addr_i;
   logic [3:0]           tok_endp_i;
   logic                 hsk_recv_i;
   logic [1:0]           hsk_type_i;
   logic                 hsk_send_o;
   logic                 hsk_sent_i;
   logic [1:0]           hsk_type_o;
   logic                 usb_send_o;
   logic                 usb_sent_i;
   logic [1:0]           usb_type_o;
   logic                 usb_tvalid_o;
   logic                 usb_tready_i;
   logic                 usb_tlast_o;
   logic [7:0]           usb_tdata_o;
   logic [NUM_EPS-1:0]   ep_ready_i;
   logic [NUM_EPS-1:0]   ep_halt_i;
   logic [NUM_EPS-1:0]   ep_clr_i;
   logic [NUM_EPS-1:0]   ep_tvalid_i;
   logic [NUM_EPS-1:0]   ep_tlast_i;
   logic [NUM_EPS-1:0]   ep_tready_o;
   logic [8*NUM_EPS-1:0] ep_tdata_i;
   logic [NUM_EPS-1:0]   ep_done_o;
   logic [NUM_EPS-1:0]   ep_retry_o;
   logic [3:0]           ep_sel_o;

   logic [25:0] all_out;
   assign all_out = {hsk_send_o, hsk_type_o, usb_send_o, usb_type_o, usb_tvalid_o, usb_tlast_o,
                     usb_tdata_o, ep_tready_o, ep_done_o, ep_retry_o, ep_sel_o};

   int checks = 0;
   int errors = 0;

   usb_bulk_in_ctrl #(.NUM_EPS(NUM_EPS), .TIMEOUT(TIMEOUT)) dut (
      .clock(clock), .reset(reset), .usb_addr_i(usb_addr_i),
      .tok_recv_i(tok_recv_i), .tok_type_i(tok_type_i), .tok_addr_i(tok_addr_i), .tok_endp_i(tok_endp_i),
      .hsk_recv_i(hsk_recv_i), .hsk_type_i(hsk_type_i), .hsk_send_o(hsk_send_o),
      .hsk_sent_i(hsk_sent_i), .hsk_type_o(hsk_type_o),
      .usb_send_o(usb_send_o), .usb_sent_i(usb_sent_i), .usb_type_o(usb_type_o),
      .usb_tvalid_o(usb_tvalid_o), .usb_tready_i(usb_tready_i), .usb_tlast_o(usb_tlast_o),
      .usb_tdata_o(usb_tdata_o),
      .ep_ready_i(ep_ready_i), .ep_halt_i(ep_halt_i), .ep_clr_i(ep_clr_i),
      .ep_tvalid_i(ep_tvalid_i), .ep_tlast_i(ep_tlast_i), .ep_tready_o(ep_tready_o),
      .ep_tdata_i(ep_tdata_i), .ep_done_o(ep_done_o), .ep_retry_o(ep_retry_o), .ep_sel_o(ep_sel_o)
   );

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic send_token(input logic [1:0] typ, input logic [6:0] addr, input logic [3:0] endp);
      tok_type_i = typ;
      tok_addr_i = addr;
      tok_endp_i = endp;
      tok_recv_i = 1'b1;
      tick();
      tok_recv_i = 1'b0;
   endtask

   // IN token, full stream (with one back-pressure cycle on beat 2), usb_sent; returns in WAIT.
   task automatic send_data(input int ep, input logic [1:0] exp_type, input int len, input logic [7:0] base);
      int ch;
      logic [NUM_EPS-1:0] rdy;
      ch = ep - 1;
      rdy = '0;
      rdy[ch] = 1'b1;
      send_token(2'b10, ADDR, 4'(ep));
      checks++;
      if (usb_send_o !== 1'b1 || usb_type_o !== exp_type || hsk_send_o !== 1'b0) begin
         errors++;
         $display("FAIL data_start ep%0d: send=%b type=%b hsk=%b, want send=1 type=%b hsk=0",
                  ep, usb_send_o, usb_type_o, hsk_send_o, exp_type);
      end
      checks++;
      if (ep_sel_o !== 4'(ep)) begin
         errors++;
         $display("FAIL ep_sel ep%0d: got %0d want %0d", ep, ep_sel_o, ep);
      end
      for (int i = 0; i < len; i++) begin
         ep_tvalid_i[ch]          = 1'b1;
         ep_tlast_i[ch]           = (i == len - 1);
         ep_tdata_i[8*ch +: 8]    = base + 8'(i);
         if (i == 1) begin
            checks++;
            if (usb_send_o !== 1'b0) begin
               errors++;
               $display("FAIL send_pulse ep%0d: usb_send_o=%b after first cycle, want 0", ep, usb_send_o);
            end
         end
         if (i == 2) begin
            usb_tready_i = 1'b0;
            #1;
            checks++;
            if (ep_tready_o !== '0 || usb_tvalid_o !== 1'b1) begin
               errors++;
               $display("FAIL backpressure ep%0d: ep_tready=%b tvalid=%b, want 0 and 1", ep, ep_tready_o, usb_tvalid_o);
            end
            tick();
            usb_tready_i = 1'b1;
         end
         #1;
         checks++;
         if (usb_tvalid_o !== 1'b1 || usb_tdata_o !== base + 8'(i) || usb_tlast_o !== (i == len - 1)
             || ep_tready_o !== rdy) begin
            errors++;
            $display("FAIL beat%0d ep%0d: v=%b d=%h l=%b r=%b, want v=1 d=%h l=%b r=%b", i, ep,
                     usb_tvalid_o, usb_tdata_o, usb_tlast_o, ep_tready_o, base + 8'(i), (i == len - 1), rdy);
         end
         tick();
      end
      ep_tvalid_i = '0;
      ep_tlast_i  = '0;
      usb_sent_i  = 1'b1;
      tick();
      usb_sent_i  = 1'b0;
      checks++;
      if (usb_tvalid_o !== 1'b0 || ep_sel_o !== 4'(ep) || usb_type_o !== exp_type) begin
         errors++;
         $display("FAIL wait_entry ep%0d: tvalid=%b sel=%0d type=%b, want 0 %0d %b",
                  ep, usb_tvalid_o, ep_sel_o, usb_type_o, ep, exp_type);
      end
   endtask

   task automatic finish_hsk(input int ep, input logic [1:0] htype, input logic exp_done);
      logic [NUM_EPS-1:0] m;
      m = '0;
      m[ep-1] = 1'b1;
      hsk_type_i = htype;
      hsk_recv_i = 1'b1;
      tick();
      hsk_recv_i = 1'b0;
      checks++;
      if (ep_done_o !== (exp_done ? m : '0) || ep_retry_o !== (exp_done ? '0 : m) || ep_sel_o !== 4'd0) begin
         errors++;
         $display("FAIL handshake ep%0d: done=%b retry=%b sel=%0d, want done=%b retry=%b sel=0",
                  ep, ep_done_o, ep_retry_o, ep_sel_o, (exp_done ? m : '0), (exp_done ? '0 : m));
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      ep_tvalid_i = '1;
      tick();
      tick();
      checks++;
      if (all_out !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got %h want 0", all_out);
      end
      reset = 1'b0;
      ep_tvalid_i = '0;
      tick();
      checks++;
      if (all_out !== '0) begin
         errors++;
         $display("FAIL post_reset_idle: got %h want 0", all_out);
      end
   endtask

   task automatic test_data_ack();
      ep_ready_i = 2'b01;
      send_data(1, 2'b00, 5, 8'h10);
      finish_hsk(1, 2'b00, 1'b1);
      tick();
      checks++;
      if (ep_done_o !== 2'b00) begin
         errors++;
         $display("FAIL done_pulse_width: ep_done_o=%b, want 00", ep_done_o);
      end
      send_data(1, 2'b10, 3, 8'h40);
      finish_hsk(1, 2'b00, 1'b1);
   endtask

   task automatic test_nak();
      ep_ready_i = 2'b01;
      send_token(2'b10, ADDR, 4'd2);
      checks++;
      if (hsk_send_o !== 1'b1 || hsk_type_o !== 2'b10 || usb_send_o !== 1'b0 || ep_sel_o !== 4'd2) begin
         errors++;
         $display("FAIL nak_start: hsk=%b type=%b usb_send=%b sel=%0d, want 1 10 0 2",
                  hsk_send_o, hsk_type_o, usb_send_o, ep_sel_o);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (hsk_send_o !== 1'b1 || ep_done_o !== '0 || ep_retry_o !== '0) begin
            errors++;
            $display("FAIL nak_hold%0d: hsk=%b done=%b retry=%b, want 1 00 00", i, hsk_send_o, ep_done_o, ep_retry_o);
         end
      end
      hsk_sent_i = 1'b1;
      tick();
      hsk_sent_i = 1'b0;
      checks++;
      if (hsk_send_o !== 1'b0 || ep_sel_o !== 4'd0 || ep_done_o !== '0 || ep_retry_o !== '0) begin
         errors++;
         $display("FAIL nak_end: hsk=%b sel=%0d done=%b retry=%b, want 0 0 00 00",
                  hsk_send_o, ep_sel_o, ep_done_o, ep_retry_o);
      end
      ep_ready_i = 2'b11;
      send_data(2, 2'b00, 3, 8'h80);
      finish_hsk(2, 2'b00, 1'b1);
   endtask

   task automatic test_stall();
      ep_halt_i      = 2'b01;
      ep_ready_i     = 2'b01;
      ep_tvalid_i[0] = 1'b1;
      send_token(2'b10, ADDR, 4'd1);
      checks++;
      if (hsk_send_o !== 1'b1 || hsk_type_o !== 2'b11 || usb_send_o !== 1'b0 || usb_tvalid_o !== 1'b0) begin
         errors++;
         $display("FAIL stall: hsk=%b type=%b usb_send=%b tvalid=%b, want 1 11 0 0",
                  hsk_send_o, hsk_type_o, usb_send_o, usb_tvalid_o);
      end
      hsk_sent_i = 1'b1;
      tick();
      hsk_sent_i = 1'b0;
      checks++;
      if (hsk_send_o !== 1'b0 || ep_sel_o !== 4'd0 || ep_done_o !== '0 || ep_retry_o !== '0) begin
         errors++;
         $display("FAIL stall_end: hsk=%b sel=%0d done=%b retry=%b, want 0 0 00 00",
                  hsk_send_o, ep_sel_o, ep_done_o, ep_retry_o);
      end
      ep_halt_i   = '0;
      ep_tvalid_i = '0;
   endtask

   task automatic test_timeout();
      logic early;
      early = 1'b0;
      ep_ready_i = 2'b01;
      send_data(1, 2'b00, 4, 8'hA0);
      // send_data returns one cycle after usb_sent; TIMEOUT more ticks reach the retry cycle.
      for (int k = 1; k <= TIMEOUT; k++) begin
         if (ep_retry_o !== '0 || ep_done_o !== '0) early = 1'b1;
         tick();
      end
      checks++;
      if (early !== 1'b0) begin
         errors++;
         $display("FAIL timeout_early: pulse seen before cycle %0d", TIMEOUT + 1);
      end
      checks++;
      if (ep_retry_o !== 2'b01 || ep_done_o !== 2'b00 || ep_sel_o !== 4'd0) begin
         errors++;
         $display("FAIL timeout_retry: retry=%b done=%b sel=%0d, want 01 00 0", ep_retry_o, ep_done_o, ep_sel_o);
      end
      send_data(1, 2'b00, 4, 8'hA0);
      finish_hsk(1, 2'b00, 1'b1);
      send_data(1, 2'b10, 3, 8'hB0);
      finish_hsk(1, 2'b00, 1'b1);
   endtask

   task automatic test_invalid();
      logic [1:0] typ  [4] = '{2'b00, 2'b10, 2'b10, 2'b10};
      logic [6:0] addr [4] = '{ADDR, ADDR ^ 7'h01, ADDR, ADDR};
      logic [3:0] endp [4] = '{4'd1, 4'd1, 4'd0, 4'd3};
      ep_ready_i = 2'b11;
      for (int i = 0; i < 4; i++) begin
         send_token(typ[i], addr[i], endp[i]);
         checks++;
         if (usb_send_o !== 1'b0 || hsk_send_o !== 1'b0 || ep_sel_o !== 4'd0
             || usb_type_o !== 2'b10 || hsk_type_o !== 2'b11 || usb_tvalid_o !== 1'b0) begin
            errors++;
            $display("FAIL invalid_tok%0d: send=%b hsk=%b sel=%0d type=%b htype=%b tvalid=%b, want 0 0 0 10 11 0",
                     i, usb_send_o, hsk_send_o, ep_sel_o, usb_type_o, hsk_type_o, usb_tvalid_o);
         end
      end
      send_data(1, 2'b00, 3, 8'hC0);
      ep_clr_i = 2'b01;
      finish_hsk(1, 2'b00, 1'b1);
      ep_clr_i = 2'b00;
      send_data(1, 2'b00, 3, 8'hD0);
      finish_hsk(1, 2'b00, 1'b1);
   endtask

   task automatic test_back_to_back();
      ep_ready_i = 2'b11;
      send_data(2, 2'b10, 3, 8'hE0);
      send_token(2'b10, ADDR, 4'd1);
      checks++;
      if (ep_retry_o !== 2'b10 || ep_done_o !== 2'b00 || usb_send_o !== 1'b0 || hsk_send_o !== 1'b0
          || ep_sel_o !== 4'd0) begin
         errors++;
         $display("FAIL token_in_wait: retry=%b done=%b send=%b hsk=%b sel=%0d, want 10 00 0 0 0",
                  ep_retry_o, ep_done_o, usb_send_o, hsk_send_o, ep_sel_o);
      end
      send_data(2, 2'b10, 3, 8'hE0);
      finish_hsk(2, 2'b10, 1'b0);
      send_data(2, 2'b10, 3, 8'hE0);
      finish_hsk(2, 2'b00, 1'b1);
   endtask

   task automatic test_reset_mid();
      ep_ready_i = 2'b01;
      send_token(2'b10, ADDR, 4'd1);
      checks++;
      if (usb_send_o !== 1'b1 || usb_type_o !== 2'b10) begin
         errors++;
         $display("FAIL pre_reset_type: send=%b type=%b, want 1 10", usb_send_o, usb_type_o);
      end
      for (int i = 0; i < 3; i++) begin
         ep_tvalid_i[0]   = 1'b1;
         ep_tlast_i[0]    = 1'b0;
         ep_tdata_i[7:0]  = 8'h60 + 8'(i);
         if (i == 2) reset = 1'b1;
         tick();
      end
      checks++;
      if (all_out !== '0) begin
         errors++;
         $display("FAIL reset_mid_outputs: got %h want 0", all_out);
      end
      reset       = 1'b0;
      ep_tvalid_i = '0;
      tick();
      checks++;
      if (ep_done_o !== '0 || ep_retry_o !== '0 || ep_sel_o !== 4'd0) begin
         errors++;
         $display("FAIL reset_mid_no_pulse: done=%b retry=%b sel=%0d, want 00 00 0", ep_done_o, ep_retry_o, ep_sel_o);
      end
      send_data(1, 2'b00, 3, 8'hF0);
      finish_hsk(1, 2'b00, 1'b1);
   endtask

   initial begin
      reset        = 1'b1;
      usb_addr_i   = ADDR;
      tok_recv_i   = 1'b0;
      tok_type_i   = 2'b00;
      tok_addr_i   = 7'd0;
      tok_endp_i   = 4'd0;
      hsk_recv_i   = 1'b0;
      hsk_type_i   = 2'b00;
      hsk_sent_i   = 1'b0;
      usb_sent_i   = 1'b0;
      usb_tready_i = 1'b1;
      ep_ready_i   = '0;
      ep_halt_i    = '0;
      ep_clr_i     = '0;
      ep_tvalid_i  = '0;
      ep_tlast_i   = '0;
      ep_tdata_i   = '0;

      test_reset();
      test_data_ack();
      test_nak();
      test_stall();
      test_timeout();
      test_invalid();
      test_back_to_back();
      test_reset_mid();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
